// File: rtl/req_arbiter4_pkg.sv
// Purpose: shared definitions for the 4-requester arbiter.
//   - state_e      : arbiter FSM states (IDLE / GRANT / GAP)
//   - REQ_N        : number of requesters
//   - idx_to_onehot: encoded requester index -> one-hot grant vector
package req_arbiter4_pkg;

  localparam int REQ_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  function automatic logic [REQ_N-1:0] idx_to_onehot(input logic [1:0] idx);
    idx_to_onehot = {{(REQ_N-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Purpose: combinational winner selection for the 4-requester arbiter.
// Ports:
//   i_req  [3:0] request vector
//   i_ptr  [1:0] round-robin start position (ignored in fixed mode)
//   i_mode       0 = fixed priority (req[3] highest), 1 = round-robin from i_ptr
//   o_idx  [1:0] winning requester index (don't-care when o_any = 0)
//   o_any        at least one request present
module rr_pick4
  import req_arbiter4_pkg::*;
(
  input  logic [REQ_N-1:0] i_req,
  input  logic [1:0]       i_ptr,
  input  logic             i_mode,
  output logic [1:0]       o_idx,
  output logic             o_any
);

  logic [2*REQ_N-1:0] w_dbl;
  logic [REQ_N-1:0]   w_rot;
  logic [1:0]         w_fix_idx;
  logic [1:0]         w_rot_idx;

  // Rotate so that bit 0 of w_rot is the requester at i_ptr.
  assign w_dbl = {i_req, i_req};
  assign w_rot = w_dbl[i_ptr +: REQ_N];

  // Fixed priority: highest set index wins.
  always_comb begin
    w_fix_idx = 2'd0;
    casez (i_req)
      4'b1???: w_fix_idx = 2'd3;
      4'b01??: w_fix_idx = 2'd2;
      4'b001?: w_fix_idx = 2'd1;
      default: w_fix_idx = 2'd0;
    endcase
  end

  // Round-robin: lowest set bit of the rotated vector is the first one met scanning from i_ptr.
  always_comb begin
    w_rot_idx = 2'd0;
    casez (w_rot)
      4'b???1: w_rot_idx = 2'd0;
      4'b??10: w_rot_idx = 2'd1;
      4'b?100: w_rot_idx = 2'd2;
      default: w_rot_idx = 2'd3;
    endcase
  end

  // Un-rotate: 2-bit addition wraps modulo 4.
  assign o_idx = i_mode ? (i_ptr + w_rot_idx) : w_fix_idx;
  assign o_any = |i_req;

endmodule

// File: rtl/req_arbiter4.sv
// Purpose: 4-requester arbiter sharing one downstream resource, with selectable
//   fixed-priority / round-robin pick, bounded grant hold and a one-cycle turnaround gap.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_en              enable; low blocks new grants and releases the active one
//   i_mode            0 = fixed priority, 1 = round-robin (sampled at pick only)
//   i_req  [3:0]      request vector
//   o_gnt  [3:0]      one-hot registered grant
//   o_gnt_idx [1:0]   encoded grant index, holds last value when no grant
//   o_gnt_valid       high iff o_gnt != 0
//   o_timeout         one-cycle pulse when a grant was force-released at MAX_HOLD
module req_arbiter4
  import req_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_mode,
  input  logic [REQ_N-1:0] i_req,
  output logic [REQ_N-1:0] o_gnt,
  output logic [1:0]       o_gnt_idx,
  output logic             o_gnt_valid,
  output logic             o_timeout
);

  state_e           r_state;
  logic [REQ_N-1:0] r_gnt;
  logic [1:0]       r_gnt_idx;
  logic             r_gnt_valid;
  logic             r_timeout;
  logic [1:0]       r_rr_ptr;
  logic [CNT_W-1:0] r_hold_cnt;

  state_e           w_state_nxt;
  logic [REQ_N-1:0] w_gnt_nxt;
  logic [1:0]       w_gnt_idx_nxt;
  logic             w_gnt_valid_nxt;
  logic             w_timeout_nxt;
  logic [1:0]       w_rr_ptr_nxt;
  logic [CNT_W-1:0] w_hold_cnt_nxt;

  logic [1:0]       w_pick_idx;
  logic             w_pick_any;
  logic             w_req_held;
  logic             w_at_limit;
  logic             w_release;
  logic             w_forced;

  rr_pick4 u_pick (
    .i_req  (i_req),
    .i_ptr  (r_rr_ptr),
    .i_mode (i_mode),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  // hold_cnt counts completed grant cycles minus one, so the limit is MAX_HOLD-1.
  assign w_req_held = i_req[r_gnt_idx];
  assign w_at_limit = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign w_release  = !w_req_held || w_at_limit || !i_en;
  // Only a release caused purely by the hold limit reports a timeout.
  assign w_forced   = w_req_held && i_en && w_at_limit;

  // Next-state and next-output logic for the arbiter FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_gnt_idx_nxt   = r_gnt_idx;
    w_gnt_valid_nxt = r_gnt_valid;
    w_timeout_nxt   = 1'b0;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_hold_cnt_nxt  = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_en && w_pick_any) begin
          w_state_nxt     = ST_GRANT;
          w_gnt_nxt       = idx_to_onehot(w_pick_idx);
          w_gnt_idx_nxt   = w_pick_idx;
          w_gnt_valid_nxt = 1'b1;
          w_hold_cnt_nxt  = {CNT_W{1'b0}};
        end else begin
          w_gnt_nxt       = {REQ_N{1'b0}};
          w_gnt_valid_nxt = 1'b0;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_state_nxt     = ST_GAP;
          w_gnt_nxt       = {REQ_N{1'b0}};
          w_gnt_valid_nxt = 1'b0;
          w_timeout_nxt   = w_forced;
          w_rr_ptr_nxt    = r_gnt_idx + 2'd1;
        end else if (r_hold_cnt != CNT_W'(MAX_HOLD)) begin
          w_hold_cnt_nxt  = r_hold_cnt + CNT_W'(1);
        end else begin
          w_hold_cnt_nxt  = r_hold_cnt;
        end
      end
      ST_GAP: begin
        w_state_nxt     = ST_IDLE;
        w_gnt_nxt       = {REQ_N{1'b0}};
        w_gnt_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_gnt_nxt       = {REQ_N{1'b0}};
        w_gnt_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_gnt       <= {REQ_N{1'b0}};
      r_gnt_idx   <= 2'd0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_rr_ptr    <= 2'd0;
      r_hold_cnt  <= {CNT_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_idx   <= w_gnt_idx_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_timeout   <= w_timeout_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_idx   = r_gnt_idx;
  assign o_gnt_valid = r_gnt_valid;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_req_arbiter4.sv
// Self-checking bench for req_arbiter4: a cycle-level behavioural model
// (owner / cycles-held / cooldown bookkeeping) is compared with the DUT every
// cycle, and directed scenarios pin literal expectations.
module tb_req_arbiter4;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  req_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_mode      (mode),
    .i_req       (req),
    .o_gnt       (gnt),
    .o_gnt_idx   (gnt_idx),
    .o_gnt_valid (gnt_valid),
    .o_timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_owner = -1;   // granted requester, -1 when none
  int         m_held = 0;     // grant cycles completed so far
  int         m_cool = 0;     // cycles left before a new pick is allowed
  int         m_ptr = 0;      // round-robin start position
  logic [3:0] m_gnt = 4'b0000;
  logic [1:0] m_idx = 2'd0;
  logic       m_to = 1'b0;

  function automatic int pick(input logic [3:0] r, input logic md, input int p);
    int w;
    w = -1;
    if (!md) begin
      for (int i = 0; i < 4; i++) if (r[i]) w = i;
    end else begin
      for (int k = 3; k >= 0; k--) if (r[(p + k) % 4]) w = (p + k) % 4;
    end
    return w;
  endfunction

  task automatic model_step();
    m_to = 1'b0;
    if (rst) begin
      m_owner = -1; m_held = 0; m_cool = 0; m_ptr = 0; m_idx = 2'd0;
    end else if (m_owner >= 0) begin
      m_held++;
      if (!req[m_owner] || !en || m_held == MAX_HOLD) begin
        m_to    = req[m_owner] && en && (m_held == MAX_HOLD);
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_cool  = 1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (en && req != 4'b0000) begin
      m_owner = pick(req, mode, m_ptr);
      m_held  = 0;
      m_idx   = 2'(m_owner);
    end
    m_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
  endtask

  // Compare process: advance the model on each edge and check outputs just after.
  always @(posedge clk) begin
    model_step();
    #1;
    check("gnt", 32'(gnt), 32'(m_gnt));
    check("gnt_idx", 32'(gnt_idx), 32'(m_idx));
    check("gnt_valid", 32'(gnt_valid), 32'(m_gnt != 4'b0000));
    check("timeout", 32'(timeout), 32'(m_to));
  end

  // Apply one cycle of inputs at the falling edge; outputs seen right after a
  // drive reflect the previous drive's edge.
  task automatic drive(input logic r, input logic e, input logic m, input logic [3:0] q);
    @(negedge clk);
    rst = r; en = e; mode = m; req = q;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 4'b0000);
  endtask

  int         gcnt;
  int         tcnt;
  int         nseq;
  logic       prev_v;
  logic [1:0] seq [5];
  logic [3:0] rq;

  initial begin
    // Reset values
    drive(1'b1, 1'b0, 1'b0, 4'b0000);
    drive(1'b0, 1'b1, 1'b0, 4'b1010);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_idx", 32'(gnt_idx), 32'h0);
    check("rst_valid", 32'(gnt_valid), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    // Scenario 1: fixed priority, 1010 -> requester 3, one cycle latency
    drive(1'b0, 1'b1, 1'b0, 4'b1010);
    check("s1_gnt", 32'(gnt), 32'h8);
    check("s1_idx", 32'(gnt_idx), 32'h3);
    check("s1_valid", 32'(gnt_valid), 32'h1);
    idle(4);

    // Scenario 2: 0110, requester 2 held 3 cycles, then requester 1
    drive(1'b0, 1'b1, 1'b0, 4'b0110);
    drive(1'b0, 1'b1, 1'b0, 4'b0110);
    check("s2_gnt_a", 32'(gnt), 32'h4);
    drive(1'b0, 1'b1, 1'b0, 4'b0110);
    drive(1'b0, 1'b1, 1'b0, 4'b0010);
    check("s2_gnt_b", 32'(gnt), 32'h4);
    drive(1'b0, 1'b1, 1'b0, 4'b0010);
    check("s2_gap", 32'(gnt), 32'h0);
    drive(1'b0, 1'b1, 1'b0, 4'b0010);
    check("s2_idle", 32'(gnt), 32'h0);
    drive(1'b0, 1'b1, 1'b0, 4'b0010);
    check("s2_gnt_c", 32'(gnt), 32'h2);
    idle(4);

    // Scenario 4: steady requester 3 -> two 8-cycle grants with timeouts
    gcnt = 0; tcnt = 0;
    for (int k = 0; k <= 20; k++) begin
      drive(1'b0, 1'b1, 1'b0, 4'b1000);
      if (k >= 1) begin
        if (gnt == 4'b1000) gcnt++;
        if (timeout) tcnt++;
      end
    end
    check("s4_gnt_cycles", 32'(gcnt), 32'd16);
    check("s4_timeouts", 32'(tcnt), 32'd2);
    idle(4);

    // Scenario 3: round-robin, all requesting -> 0,1,2,3,0
    nseq = 0; tcnt = 0; prev_v = 1'b0;
    for (int k = 0; k <= 50; k++) begin
      drive(1'b0, 1'b1, 1'b1, 4'b1111);
      if (k >= 1) begin
        if (gnt_valid && !prev_v && nseq < 5) begin
          seq[nseq] = gnt_idx;
          nseq++;
        end
        if (timeout) tcnt++;
        prev_v = gnt_valid;
      end
    end
    check("s3_grants", 32'(nseq), 32'd5);
    check("s3_seq0", 32'(seq[0]), 32'd0);
    check("s3_seq1", 32'(seq[1]), 32'd1);
    check("s3_seq2", 32'(seq[2]), 32'd2);
    check("s3_seq3", 32'(seq[3]), 32'd3);
    check("s3_seq4", 32'(seq[4]), 32'd0);
    check("s3_timeouts", 32'(tcnt), 32'd5);
    idle(4);

    // Scenario 5: drop en during grant to requester 1
    drive(1'b0, 1'b1, 1'b0, 4'b0010);
    drive(1'b0, 1'b1, 1'b0, 4'b0010);
    check("s5_gnt", 32'(gnt), 32'h2);
    drive(1'b0, 1'b0, 1'b0, 4'b0010);
    drive(1'b0, 1'b0, 1'b0, 4'b0010);
    check("s5_released", 32'(gnt), 32'h0);
    check("s5_no_timeout", 32'(timeout), 32'h0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 4'b0010);
      check("s5_blocked", 32'(gnt), 32'h0);
    end
    idle(4);

    // Scenario 6: reset mid-grant of requester 2, then round-robin restarts at 0
    for (int k = 0; k < 6; k++) drive(1'b0, 1'b1, 1'b0, 4'b0100);
    drive(1'b1, 1'b1, 1'b0, 4'b0100);
    drive(1'b0, 1'b1, 1'b1, 4'b0101);
    check("s6_rst_gnt", 32'(gnt), 32'h0);
    check("s6_rst_idx", 32'(gnt_idx), 32'h0);
    check("s6_rst_valid", 32'(gnt_valid), 32'h0);
    check("s6_rst_timeout", 32'(timeout), 32'h0);
    drive(1'b0, 1'b1, 1'b1, 4'b0101);
    check("s6_gnt", 32'(gnt), 32'h1);
    check("s6_idx", 32'(gnt_idx), 32'h0);

    // Randomised traffic with sticky requests; the model checks every cycle
    rq = 4'b0000;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 15) != 0),
            1'($urandom_range(0, 1)), rq);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
